// File: rtl/pc_update_unit.sv
// pc_update_unit: program counter with branch/jump/exception-return select,
// exception entry (EPC/Cause), saturating taken-branch counter and error flags.
module pc_update_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] EXC_VECTOR = 16'h0100
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWrite,
  input  logic        isBranch,
  input  logic        isBIEQ,
  input  logic [2:0]  PCSrc,
  input  logic        Zero,
  input  logic [15:0] ALUResult,
  input  logic [15:0] ALUOut,
  input  logic [15:0] RegA,
  input  logic [11:0] Imm12,
  input  logic        EPCWrite,
  input  logic        CauseWrite,
  input  logic        IntCause,
  output logic [15:0] PC,
  output logic [15:0] EPC,
  output logic [15:0] Cause,
  output logic        BranchTaken,
  output logic [15:0] BranchCount,
  output logic        Misaligned,
  output logic        BadPCSrc
);
  logic [15:0] pc_q, pc_d, epc_q, epc_d, cause_q, cause_d, cnt_q, cnt_d, target;
  logic        mis_q, mis_d, bad_q, bad_d, pc_en, src_ok, load;
  always_comb begin
    BranchTaken = isBranch & (isBIEQ ? Zero : ~Zero);
    pc_en       = PCWrite | BranchTaken;
    src_ok      = PCSrc <= 3'd4;
    target      = PCSrc == 3'd0 ? ALUResult :
                  PCSrc == 3'd1 ? ALUOut :
                  PCSrc == 3'd2 ? RegA :
                  PCSrc == 3'd3 ? {pc_q[15:12], Imm12} : epc_q;
    // exception entry overrides any normal PC load, including its error side effects
    load        = pc_en & src_ok & ~EPCWrite;
    pc_d        = EPCWrite ? EXC_VECTOR : load ? {target[15:1], 1'b0} : pc_q;
    epc_d       = EPCWrite ? pc_q - 16'd2 : epc_q;
    cause_d     = CauseWrite ? {15'b0, IntCause} : cause_q;
    cnt_d       = (BranchTaken && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    mis_d       = load & target[0];
    bad_d       = bad_q | (pc_en & ~src_ok & ~EPCWrite);
  end
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      cause_q <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      bad_q   <= bad_d;
    end
  end
  assign PC          = pc_q;
  assign EPC         = epc_q;
  assign Cause       = cause_q;
  assign BranchCount = cnt_q;
  assign Misaligned  = mis_q;
  assign BadPCSrc    = bad_q;
endmodule

// File: tb/tb_pc_update_unit.sv
// tb_pc_update_unit: table-driven scoreboard bench for pc_update_unit.
module tb_pc_update_unit;
  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        PCWrite, isBranch, isBIEQ, Zero, EPCWrite, CauseWrite, IntCause;
  logic [2:0]  PCSrc;
  logic [15:0] ALUResult, ALUOut, RegA;
  logic [11:0] Imm12;
  logic [15:0] PC, EPC, Cause, BranchCount;
  logic        BranchTaken, Misaligned, BadPCSrc;

  typedef struct packed {
    logic pcw, isb, bieq, zero;
    logic [2:0] src;
    logic [15:0] alur, aluo, rega;
    logic [11:0] imm;
    logic epcw, cw, ic;
  } stim_t;

  int checks = 0;
  int failures = 0;
  logic [65:0] sb[$];

  pc_update_unit dut (
    .CLK(CLK), .Reset(Reset), .PCWrite(PCWrite), .isBranch(isBranch), .isBIEQ(isBIEQ),
    .PCSrc(PCSrc), .Zero(Zero), .ALUResult(ALUResult), .ALUOut(ALUOut), .RegA(RegA),
    .Imm12(Imm12), .EPCWrite(EPCWrite), .CauseWrite(CauseWrite), .IntCause(IntCause),
    .PC(PC), .EPC(EPC), .Cause(Cause), .BranchTaken(BranchTaken),
    .BranchCount(BranchCount), .Misaligned(Misaligned), .BadPCSrc(BadPCSrc)
  );

  always #5 CLK = ~CLK;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic stim_t mk(logic pcw, logic isb, logic bieq, logic zero, logic [2:0] src,
                               logic [15:0] alur, logic [15:0] aluo, logic [15:0] rega,
                               logic [11:0] imm, logic epcw, logic cw, logic ic);
    return '{pcw, isb, bieq, zero, src, alur, aluo, rega, imm, epcw, cw, ic};
  endfunction

  function automatic logic [65:0] ev(logic [15:0] pc, logic [15:0] epc, logic [15:0] cause,
                                     logic [15:0] cnt, logic mis, logic bad);
    return {pc, epc, cause, cnt, mis, bad};
  endfunction

  function automatic logic [65:0] obs();
    return {PC, EPC, Cause, BranchCount, Misaligned, BadPCSrc};
  endfunction

  task automatic apply(input stim_t s);
    PCWrite = s.pcw; isBranch = s.isb; isBIEQ = s.bieq; Zero = s.zero; PCSrc = s.src;
    ALUResult = s.alur; ALUOut = s.aluo; RegA = s.rega; Imm12 = s.imm;
    EPCWrite = s.epcw; CauseWrite = s.cw; IntCause = s.ic;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [65:0] got, exp;
    apply(mk(1, 1, 1, 1, 0, 16'h0002, 0, 0, 0, 0, 1, 1));
    #1;
    sb.push_back(ev(16'h0000, 0, 0, 0, 0, 0));
    got = obs(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_async: got %h exp %h", got, exp); end
    sb.push_back(ev(16'h0000, 0, 0, 0, 0, 0));
    tick();
    got = obs(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_held_edge: got %h exp %h", got, exp); end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    Reset = 1'b0;
  endtask

  task automatic test_branch_taken_comb();
    logic exp;
    for (int i = 0; i < 8; i++) begin
      isBranch = i[2]; isBIEQ = i[1]; Zero = i[0];
      #1;
      exp = i[2] & (i[1] ? i[0] : ~i[0]);
      checks++;
      if (BranchTaken !== exp) begin
        failures++;
        $display("FAIL branch_taken_comb[%0d]: got %b exp %b", i, BranchTaken, exp);
      end
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic test_fetch_branch();
    stim_t s[$];
    logic [65:0] e[$], got, exp;
    s.push_back(mk(1, 0, 0, 0, 0, 16'h0002, 0, 0, 0, 0, 0, 0)); e.push_back(ev(16'h0002, 0, 0, 0, 0, 0));
    s.push_back(mk(1, 0, 0, 0, 0, 16'h1234, 0, 0, 0, 0, 0, 0)); e.push_back(ev(16'h1234, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 1, 1, 1, 1, 0, 16'h1240, 0, 0, 0, 0, 0)); e.push_back(ev(16'h1240, 0, 0, 1, 0, 0));
    s.push_back(mk(0, 1, 0, 1, 1, 0, 16'h5550, 0, 0, 0, 0, 0)); e.push_back(ev(16'h1240, 0, 0, 1, 0, 0));
    s.push_back(mk(0, 1, 0, 0, 2, 0, 0, 16'h2001, 0, 0, 0, 0)); e.push_back(ev(16'h2000, 0, 0, 2, 1, 0));
    s.push_back(mk(0, 0, 0, 0, 2, 0, 0, 16'h4444, 0, 0, 0, 0)); e.push_back(ev(16'h2000, 0, 0, 2, 0, 0));
    s.push_back(mk(1, 1, 1, 0, 1, 0, 16'h3000, 0, 0, 0, 0, 0)); e.push_back(ev(16'h3000, 0, 0, 2, 0, 0));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(e[i]); tick();
      got = obs(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL fetch_branch[%0d]: got %h exp %h", i, got, exp); end
    end
  endtask

  task automatic test_jump();
    stim_t s[$];
    logic [65:0] e[$], got, exp;
    s.push_back(mk(1, 0, 0, 0, 0, 16'hA010, 0, 0, 0, 0, 0, 0));     e.push_back(ev(16'hA010, 0, 0, 2, 0, 0));
    s.push_back(mk(1, 0, 0, 0, 3, 0, 0, 0, 12'h3FF, 0, 0, 0));      e.push_back(ev(16'hA3FE, 0, 0, 2, 1, 0));
    s.push_back(mk(0, 0, 0, 0, 3, 0, 0, 0, 12'h111, 0, 0, 0));      e.push_back(ev(16'hA3FE, 0, 0, 2, 0, 0));
    s.push_back(mk(1, 0, 0, 0, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0));     e.push_back(ev(16'hFFFE, 0, 0, 2, 1, 0));
    s.push_back(mk(1, 0, 0, 0, 3, 0, 0, 0, 12'h002, 0, 0, 0));      e.push_back(ev(16'hF002, 0, 0, 2, 0, 0));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(e[i]); tick();
      got = obs(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL jump[%0d]: got %h exp %h", i, got, exp); end
    end
  endtask

  task automatic test_exception();
    stim_t s[$];
    logic [65:0] e[$], got, exp;
    s.push_back(mk(1, 0, 0, 0, 0, 16'h0040, 0, 0, 0, 0, 0, 0)); e.push_back(ev(16'h0040, 0, 0, 2, 0, 0));
    s.push_back(mk(1, 0, 0, 0, 0, 16'h5555, 0, 0, 0, 1, 1, 1)); e.push_back(ev(16'h0100, 16'h003E, 1, 2, 0, 0));
    s.push_back(mk(1, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0));        e.push_back(ev(16'h003E, 16'h003E, 1, 2, 0, 0));
    s.push_back(mk(1, 1, 1, 1, 6, 0, 0, 0, 0, 1, 0, 0));        e.push_back(ev(16'h0100, 16'h003C, 1, 3, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));        e.push_back(ev(16'h0100, 16'h003C, 0, 3, 0, 0));
    s.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0)); e.push_back(ev(16'h0000, 16'h003C, 0, 3, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));        e.push_back(ev(16'h0100, 16'hFFFE, 0, 3, 0, 0));
    s.push_back(mk(1, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0));        e.push_back(ev(16'hFFFE, 16'hFFFE, 0, 3, 0, 0));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(e[i]); tick();
      got = obs(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL exception[%0d]: got %h exp %h", i, got, exp); end
    end
  endtask

  task automatic test_bad_pcsrc();
    stim_t s[$];
    logic [65:0] e[$], got, exp;
    s.push_back(mk(1, 0, 0, 0, 6, 16'h1234, 0, 0, 0, 0, 0, 0)); e.push_back(ev(16'hFFFE, 16'hFFFE, 0, 3, 0, 1));
    for (int k = 0; k < 10; k++) begin
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));      e.push_back(ev(16'hFFFE, 16'hFFFE, 0, 3, 0, 1));
    end
    s.push_back(mk(0, 1, 1, 1, 7, 16'h0800, 0, 0, 0, 0, 0, 0)); e.push_back(ev(16'hFFFE, 16'hFFFE, 0, 4, 0, 1));
    s.push_back(mk(1, 0, 0, 0, 0, 16'h0010, 0, 0, 0, 0, 0, 0)); e.push_back(ev(16'h0010, 16'hFFFE, 0, 4, 0, 1));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(e[i]); tick();
      got = obs(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL bad_pcsrc[%0d]: got %h exp %h", i, got, exp); end
    end
    Reset = 1'b1;
    #1;
    got = obs(); checks++;
    if (got !== ev(16'h0000, 0, 0, 0, 0, 0)) begin
      failures++; $display("FAIL bad_pcsrc_reset: got %h exp %h", got, ev(16'h0000, 0, 0, 0, 0, 0));
    end
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_epc_reset_return();
    stim_t s[$];
    logic [65:0] e[$], got, exp;
    s.push_back(mk(1, 0, 0, 0, 0, 16'h0800, 0, 0, 0, 0, 0, 0)); e.push_back(ev(16'h0800, 0, 0, 0, 0, 0));
    s.push_back(mk(1, 0, 0, 0, 4, 16'h0900, 0, 0, 0, 0, 0, 0)); e.push_back(ev(16'h0000, 0, 0, 0, 0, 0));
    s.push_back(mk(1, 0, 0, 0, 5, 16'h0900, 0, 0, 0, 0, 0, 0)); e.push_back(ev(16'h0000, 0, 0, 0, 0, 1));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(e[i]); tick();
      got = obs(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL epc_reset_return[%0d]: got %h exp %h", i, got, exp); end
    end
  endtask

  task automatic test_saturate_and_reset();
    stim_t s[$];
    logic [65:0] e[$], got, exp;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    apply(mk(0, 1, 1, 1, 0, 16'h0010, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 16'hFFFE; k++) tick();
    sb.push_back(ev(16'h0010, 0, 0, 16'hFFFE, 0, 0));
    got = obs(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL preload_fffe: got %h exp %h", got, exp); end
    for (int k = 0; k < 3; k++) begin
      s.push_back(mk(0, 1, 1, 1, 0, 16'h0010, 0, 0, 0, 0, 0, 0)); e.push_back(ev(16'h0010, 0, 0, 16'hFFFF, 0, 0));
    end
    s.push_back(mk(0, 1, 0, 0, 0, 16'h0021, 0, 0, 0, 0, 0, 0));   e.push_back(ev(16'h0020, 0, 0, 16'hFFFF, 1, 0));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(e[i]); tick();
      got = obs(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL saturate[%0d]: got %h exp %h", i, got, exp); end
    end
    apply(mk(1, 0, 0, 0, 0, 16'h7777, 0, 0, 0, 1, 1, 1));
    #2;
    Reset = 1'b1;
    #1;
    sb.push_back(ev(16'h0000, 0, 0, 0, 0, 0));
    got = obs(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_mid_cycle: got %h exp %h", got, exp); end
    sb.push_back(ev(16'h0000, 0, 0, 0, 0, 0));
    tick();
    got = obs(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_discard: got %h exp %h", got, exp); end
    Reset = 1'b0;
    apply(mk(1, 0, 0, 0, 0, 16'h0042, 0, 0, 0, 0, 0, 0));
    sb.push_back(ev(16'h0042, 0, 0, 0, 0, 0));
    tick();
    got = obs(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL first_edge_after_reset: got %h exp %h", got, exp); end
  endtask

  initial begin
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    test_reset();
    test_branch_taken_comb();
    test_fetch_branch();
    test_jump();
    test_exception();
    test_bad_pcsrc();
    test_epc_reset_return();
    test_saturate_and_reset();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_drain: got %0d entries exp 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
